mac_seq_ctrl: RTL and testbench

Job sequencer for one MAC datapath block (four 8-bit-class multipliers sharing B0, mode-selectable combine, accumulator with init value, 1-cycle registered output). Accepts a job command (mode, length, accumulate flag, init value) over valid/ready, loads the MAC config, streams operand beats into the MAC with valid/ready flow control, and waits out the MAC output latency. It then captures the result and holds it until the consumer accepts it. Sits between the fabric/host command path and the MAC datapath.

---
 rtl/mac_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for a four-lane MAC datapath: takes a job command, loads the MAC
// config, streams operand beats, waits out the MAC latency and holds the result.
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif
`ifndef MAC_MIN_WIDTH
`define MAC_MIN_WIDTH 8
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 8
`endif
`ifndef MAC_SINGLE
`define MAC_SINGLE 2'd0
`endif
`ifndef MAC_DUAL
`define MAC_DUAL 2'd1
`endif
`ifndef MAC_QUAD
`define MAC_QUAD 2'd2
`endif

module mac_seq_ctrl #(
    parameter int unsigned CNT_WIDTH  = 8,
    parameter int unsigned ACC_WIDTH  = `MAC_ACC_WIDTH,
    parameter int unsigned MIN_WIDTH  = `MAC_MIN_WIDTH,
    parameter int unsigned CONF_WIDTH = `MAC_CONF_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [1:0]                      cmd_mode,
    input  logic                            cmd_acc,
    input  logic [CNT_WIDTH-1:0]            cmd_len,
    input  logic [ACC_WIDTH-1:0]            cmd_init,
    input  logic                            op_valid,
    output logic                            op_ready,
    input  logic [4*MIN_WIDTH-1:0]          op_a,
    input  logic [MIN_WIDTH-1:0]            op_b,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [ACC_WIDTH-1:0]            res_data,
    output logic                            busy,
    output logic                            mac_rst,
    output logic                            mac_en,
    output logic [ACC_WIDTH+CONF_WIDTH-1:0] mac_cfg,
    output logic [MIN_WIDTH-1:0]            mac_a0,
    output logic [MIN_WIDTH-1:0]            mac_a1,
    output logic [MIN_WIDTH-1:0]            mac_a2,
    output logic [MIN_WIDTH-1:0]            mac_a3,
    output logic [MIN_WIDTH-1:0]            mac_b0,
    input  logic [ACC_WIDTH-1:0]            mac_c
);

    localparam int unsigned CFG_WIDTH = ACC_WIDTH + CONF_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   len_q;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   beat_c;
    logic [CFG_WIDTH-1:0]   cfg_c;

    // op_ready is high exactly in RUN, so it doubles as the RUN-state qualifier
    assign beat_c = op_ready & op_valid;
    assign mac_en = beat_c;
    assign mac_a0 = op_ready ? op_a[0*MIN_WIDTH +: MIN_WIDTH] : '0;
    assign mac_a1 = op_ready ? op_a[1*MIN_WIDTH +: MIN_WIDTH] : '0;
    assign mac_a2 = op_ready ? op_a[2*MIN_WIDTH +: MIN_WIDTH] : '0;
    assign mac_a3 = op_ready ? op_a[3*MIN_WIDTH +: MIN_WIDTH] : '0;
    assign mac_b0 = op_ready ? op_b : '0;

    // Config word: init in the top field, acc flag at the top of the conf field, mode in the LSBs
    always_comb begin
        cfg_c                              = '0;
        cfg_c[CFG_WIDTH-1:CONF_WIDTH]      = cmd_init;
        cfg_c[CONF_WIDTH-1]                = cmd_acc;
        cfg_c[1:0]                         = cmd_mode;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            op_ready  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            busy      <= 1'b0;
            mac_rst   <= 1'b1;
            mac_cfg   <= '0;
            cnt       <= '0;
            len_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    mac_rst <= 1'b0;
                    if (cmd_valid) begin
                        state     <= S_LOAD;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        mac_rst   <= 1'b1;
                        mac_cfg   <= cfg_c;
                        len_q     <= cmd_acc ? cmd_len : CNT_WIDTH'(1);
                    end
                end
                S_LOAD: begin
                    mac_rst <= 1'b0;
                    cnt     <= len_q;
                    if (len_q == '0) begin
                        state <= S_DRAIN;
                    end else begin
                        state    <= S_RUN;
                        op_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (beat_c && (cnt != '0)) begin
                        cnt <= cnt - CNT_WIDTH'(1);
                        if (cnt == CNT_WIDTH'(1)) begin
                            state    <= S_DRAIN;
                            op_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    res_data  <= mac_c;
                    res_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    op_ready  <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized self-checking bench for mac_seq_ctrl with a behavioural MAC attached
// and a job-level reference model for expected results and handshake timing.
`timescale 1ns/1ps

module tb_mac_seq_ctrl;

    localparam int unsigned CW = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned MW = 8;
    localparam int unsigned FW = 8;

    logic            clk;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_mode;
    logic            cmd_acc;
    logic [CW-1:0]   cmd_len;
    logic [AW-1:0]   cmd_init;
    logic            op_valid;
    logic            op_ready;
    logic [4*MW-1:0] op_a;
    logic [MW-1:0]   op_b;
    logic            res_valid;
    logic            res_ready;
    logic [AW-1:0]   res_data;
    logic            busy;
    logic            mac_rst;
    logic            mac_en;
    logic [AW+FW-1:0] mac_cfg;
    logic [MW-1:0]   mac_a0, mac_a1, mac_a2, mac_a3, mac_b0;
    logic [AW-1:0]   mac_c;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] a_tab [16];
    logic [7:0]  b_tab [16];
    bit          vpat  [32];
    int          vpat_len;
    bit          use_tab;

    mac_seq_ctrl #(.CNT_WIDTH(CW), .ACC_WIDTH(AW), .MIN_WIDTH(MW), .CONF_WIDTH(FW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_acc(cmd_acc), .cmd_len(cmd_len), .cmd_init(cmd_init),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .mac_rst(mac_rst), .mac_en(mac_en), .mac_cfg(mac_cfg),
        .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_a2(mac_a2), .mac_a3(mac_a3),
        .mac_b0(mac_b0), .mac_c(mac_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MAC: registered accumulator, loads init while mac_rst is high
    logic [31:0] mac_acc;
    logic [31:0] mac_prod;
    always_comb begin
        case (mac_cfg[1:0])
            2'd0:    mac_prod = 32'(mac_a0) * 32'(mac_b0);
            2'd1:    mac_prod = 32'({mac_a1, mac_a0}) * 32'(mac_b0);
            2'd2:    mac_prod = 32'({mac_a3, mac_a2, mac_a1, mac_a0}) * 32'(mac_b0);
            default: mac_prod = 32'd0;
        endcase
    end
    always @(posedge clk) begin
        if (mac_rst)     mac_acc <= mac_cfg[AW+FW-1:FW];
        else if (mac_en) mac_acc <= (mac_cfg[FW-1] ? mac_acc : 32'd0) + mac_prod;
    end
    assign mac_c = mac_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] prod(input logic [1:0] mode, input logic [31:0] a, input logic [7:0] b);
        case (mode)
            2'd0:    return 32'(a[7:0]) * 32'(b);
            2'd1:    return 32'(a[15:0]) * 32'(b);
            2'd2:    return a * 32'(b);
            default: return 32'd0;
        endcase
    endfunction

    // One full job; every task call starts and ends 1 ns after a rising edge
    task automatic run_job(input logic [1:0] mode, input bit acc, input logic [7:0] len,
                           input logic [31:0] init, input int hold, input int abort_at);
        int eff, beats, cyc, en_cnt;
        logic [31:0] exp, a;
        logic [7:0]  b;
        logic [39:0] cfg_exp;
        bit v;
        eff     = acc ? int'(len) : 1;
        exp     = acc ? init : 32'd0;
        cfg_exp = {init, acc, 5'b0, mode};

        // IDLE: present the command
        cmd_valid = 1'b1; cmd_mode = mode; cmd_acc = acc; cmd_len = len; cmd_init = init;
        op_valid = 1'b1; op_a = $urandom; op_b = 8'($urandom); res_ready = 1'($urandom_range(0, 1));
        #2;
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_op_ready", 64'(op_ready), 64'd0);
        check("idle_mac_rst", 64'(mac_rst), 64'd0);
        check("idle_mac_en", 64'(mac_en), 64'd0);
        @(posedge clk); #1;

        // LOAD: command fields scrambled to show they were latched
        cmd_valid = 1'($urandom_range(0, 1)); cmd_init = $urandom; cmd_mode = 2'($urandom);
        #2;
        check("load_mac_rst", 64'(mac_rst), 64'd1);
        check("load_cmd_ready", 64'(cmd_ready), 64'd0);
        check("load_op_ready", 64'(op_ready), 64'd0);
        check("load_busy", 64'(busy), 64'd1);
        check("load_mac_cfg", 64'(mac_cfg), 64'(cfg_exp));
        @(posedge clk); #1;
        cmd_valid = 1'b0;

        // RUN
        beats = 0; cyc = 0; en_cnt = 0;
        while (beats < eff) begin
            if (beats == abort_at) begin
                rst = 1'b1; op_valid = 1'b1;
                #2;
                @(posedge clk); #1;
                #2;
                check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_res_valid", 64'(res_valid), 64'd0);
                check("abort_res_data", 64'(res_data), 64'd0);
                check("abort_op_ready", 64'(op_ready), 64'd0);
                check("abort_mac_cfg", 64'(mac_cfg), 64'd0);
                check("abort_mac_rst", 64'(mac_rst), 64'd1);
                rst = 1'b0; op_valid = 1'b0;
                @(posedge clk); #1;
                return;
            end
            if (cyc >= 200) begin
                check("run_timeout", 64'(beats), 64'(eff));
                break;
            end
            if (use_tab) begin
                v = (cyc < vpat_len) ? vpat[cyc] : 1'b1;
                a = a_tab[beats]; b = b_tab[beats];
            end else begin
                v = ($urandom_range(0, 3) != 0);
                a = $urandom; b = 8'($urandom);
            end
            op_valid = v; op_a = a; op_b = b;
            #2;
            check("run_op_ready", 64'(op_ready), 64'd1);
            check("run_mac_rst", 64'(mac_rst), 64'd0);
            check("run_mac_en", 64'(mac_en), 64'(v));
            check("run_mac_a", 64'({mac_a3, mac_a2, mac_a1, mac_a0}), 64'(a));
            check("run_mac_b0", 64'(mac_b0), 64'(b));
            check("run_res_valid", 64'(res_valid), 64'd0);
            if (mac_en) en_cnt++;
            if (v) begin
                beats++;
                exp = acc ? exp + prod(mode, a, b) : prod(mode, a, b);
            end
            cyc++;
            @(posedge clk); #1;
        end

        // DRAIN
        op_valid = 1'b1; op_a = $urandom; op_b = 8'($urandom);
        #2;
        check("drain_mac_en_pulses", 64'(en_cnt), 64'(eff));
        check("drain_op_ready", 64'(op_ready), 64'd0);
        check("drain_mac_en", 64'(mac_en), 64'd0);
        check("drain_mac_operands", 64'({mac_a3, mac_a2, mac_a1, mac_a0, mac_b0}), 64'd0);
        check("drain_res_valid", 64'(res_valid), 64'd0);
        check("drain_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        op_valid = 1'b0;

        // DONE with optional backpressure; stray commands must be ignored
        for (int h = 0; h <= hold; h++) begin
            res_ready = (h == hold);
            cmd_valid = 1'($urandom_range(0, 1));
            #2;
            check("done_res_valid", 64'(res_valid), 64'd1);
            check("done_res_data", 64'(res_data), 64'(exp));
            check("done_cmd_ready", 64'(cmd_ready), 64'd0);
            check("done_busy", 64'(busy), 64'd1);
            check("done_mac_cfg", 64'(mac_cfg), 64'(cfg_exp));
            @(posedge clk); #1;
        end
        res_ready = 1'b0; cmd_valid = 1'b0;
        #2;
        check("back_idle_res_valid", 64'(res_valid), 64'd0);
        check("back_idle_cmd_ready", 64'(cmd_ready), 64'd1);
        check("back_idle_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_acc = 1'b0; cmd_len = '0;
        cmd_init = '0; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
        use_tab = 1'b0; vpat_len = 0;
        repeat (3) @(posedge clk);
        #1;
        op_valid = 1'b1; cmd_valid = 1'b1;
        #2;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_op_ready", 64'(op_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mac_en", 64'(mac_en), 64'd0);
        check("rst_mac_rst", 64'(mac_rst), 64'd1);
        check("rst_mac_cfg", 64'(mac_cfg), 64'd0);
        rst = 1'b0; op_valid = 1'b0; cmd_valid = 1'b0;
        @(posedge clk); #1;

        // Single accumulate: 10 + 2*5 + 3*5 + 4*5 = 55
        use_tab = 1'b1; vpat_len = 0;
        a_tab[0] = 32'd2; a_tab[1] = 32'd3; a_tab[2] = 32'd4;
        b_tab[0] = 8'd5;  b_tab[1] = 8'd5;  b_tab[2] = 8'd5;
        run_job(2'd0, 1'b1, 8'd3, 32'd10, 0, -1);

        // Dual multiply-only, len field ignored
        a_tab[0] = 32'h0000_1234; b_tab[0] = 8'h02;
        run_job(2'd1, 1'b0, 8'd7, 32'hdead_beef, 1, -1);

        // Bubbles
        vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1; vpat[4] = 1; vpat[5] = 0; vpat[6] = 1;
        vpat_len = 7;
        for (int i = 0; i < 4; i++) begin
            a_tab[i] = 32'd1; b_tab[i] = 8'd1;
        end
        run_job(2'd0, 1'b1, 8'd4, 32'd0, 0, -1);

        // Backpressure on the result
        use_tab = 1'b0; vpat_len = 0;
        run_job(2'd2, 1'b1, 8'd2, $urandom, 6, -1);

        // Accumulate with zero length returns init
        run_job(2'd0, 1'b1, 8'd0, 32'h55, 0, -1);

        // Reset mid-RUN after two beats, then a short job
        run_job(2'd0, 1'b1, 8'd5, $urandom, 0, 2);
        run_job(2'd0, 1'b1, 8'd1, $urandom, 0, -1);

        for (int j = 0; j < 30; j++) begin
            run_job(2'($urandom), 1'($urandom), 8'($urandom_range(0, 6)), $urandom,
                    $urandom_range(0, 3), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
